mem_arbiter: RTL

- Two-port arbiter and sequencer in front of the shared 16-bit word memory.
- Port A is the CPU datapath; port B is the loader/debug path that fills initial orders.
- Converts a simple per-port req/ack handshake into the memory's level-held rd/wrt protocol: assert, wait busy high, release, wait busy low.
- Adds round-robin or fixed-priority selection and a sticky timeout error.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the shared 16-bit word memory: turns per-port req/ack
// handshakes into the memory's level-held rd/wrt strobes, with a sticky timeout flag.
module mem_arbiter #(
  parameter bit          RR_EN   = 1'b1,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [9:0]  a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [9:0]  b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic [9:0]  mem_adr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wrt,
  input  logic        mem_busy,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        grant_b,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_IDLE = 2'd2,
    ST_ACK       = 2'd3
  } state_t;

  // Counter value on the last cycle allowed before aborting.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        last_b_r;
  logic        we_r;
  logic        any_req_s;
  logic        pick_b_s;
  logic        timeout_s;

  assign any_req_s = a_req | b_req;
  assign timeout_s = (cnt_r == CNT_LAST);

  // Arbitration choice for the next IDLE grant
  always_comb begin
    pick_b_s = 1'b0;
    if (a_req && b_req) begin
      if (RR_EN) begin
        pick_b_s = ~last_b_r;
      end else begin
        pick_b_s = 1'b0;
      end
    end else begin
      pick_b_s = b_req;
    end
  end

  // Sequencer: grant, hold strobe until busy, wait for busy to clear, then ack
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      last_b_r  <= 1'b1;
      we_r      <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= 16'h0000;
      b_rdata   <= 16'h0000;
      mem_adr   <= 10'd0;
      mem_wdata <= 16'h0000;
      mem_rd    <= 1'b0;
      mem_wrt   <= 1'b0;
      busy      <= 1'b0;
      grant_b   <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r  <= ST_ISSUE;
            busy     <= 1'b1;
            cnt_r    <= 8'd0;
            grant_b  <= pick_b_s;
            last_b_r <= pick_b_s;
            if (pick_b_s) begin
              we_r      <= b_we;
              mem_adr   <= b_addr;
              mem_wdata <= b_wdata;
              mem_rd    <= ~b_we;
              mem_wrt   <= b_we;
            end else begin
              we_r      <= a_we;
              mem_adr   <= a_addr;
              mem_wdata <= a_wdata;
              mem_rd    <= ~a_we;
              mem_wrt   <= a_we;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_busy) begin
            mem_rd  <= 1'b0;
            mem_wrt <= 1'b0;
            cnt_r   <= 8'd0;
            state_r <= ST_WAIT_IDLE;
          end else if (timeout_s) begin
            // Abort: the transaction is dropped but the requester still gets its ack.
            mem_rd  <= 1'b0;
            mem_wrt <= 1'b0;
            err     <= 1'b1;
            a_ack   <= ~grant_b;
            b_ack   <= grant_b;
            state_r <= ST_ACK;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_WAIT_IDLE: begin
          if (!mem_busy) begin
            if (!we_r) begin
              if (grant_b) begin
                b_rdata <= mem_rdata;
              end else begin
                a_rdata <= mem_rdata;
              end
            end
            a_ack   <= ~grant_b;
            b_ack   <= grant_b;
            state_r <= ST_ACK;
          end else if (timeout_s) begin
            err     <= 1'b1;
            a_ack   <= ~grant_b;
            b_ack   <= grant_b;
            state_r <= ST_ACK;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_ACK: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          mem_rd  <= 1'b0;
          mem_wrt <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
